lsb_ev: RTL
===========

Name: lsb_ev

Overview:
Parametrised LED/switch/button I/O block with per-input synchroniser, debouncer, sticky edge-event latches and a level interrupt. LEDs support load/set/clear/toggle writes, so software need not read-modify-write. Sits on the I/O bus beside the other I/O devices; the CPU reaches it through a 4-word register window, and irq feeds the interrupt controller.

Parameters:
NUM_LED, 8, number of LEDs (1..16)
NUM_BTN, 4, number of buttons (1..8)
NUM_SWI, 4, number of switches (1..8)
BTN_POL, 1, button active level (1 = active high)
SWI_POL, 1, switch active level (1 = active high)
DBNC_CYCLES, 20000, cycles an input must differ from its debounced value before the value flips (>=2)

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  asynchronous, active-low reset
wr  in  1  register write strobe, one cycle per write
addr  in  2  register select
data_in  in  32  write data
data_out  out  32  read data, combinational from addr
btn_in  in  NUM_BTN  raw button pins
swi_in  in  NUM_SWI  raw switch pins
leds  out  NUM_LED  LED drive, registered
btn  out  NUM_BTN  debounced buttons, active-high
swi  out  NUM_SWI  debounced switches, active-high
irq  out  1  registered interrupt request, level

Behaviour:
- Reset (rst_n low, async): leds, btn, swi, sync flops, debounce counters, event register, irq-enable and irq all 0.
- Polarity: raw input XOR ~POL gives an active-high signal, then a 2-flop synchroniser.
- Debounce, per input:
  - Counter width clog2(DBNC_CYCLES).
  - If sync == out: counter cleared.
  - Otherwise the counter increments. When it reaches DBNC_CYCLES-1 and sync still differs, out <= sync and the counter clears.
  - A glitch shorter than DBNC_CYCLES cycles never propagates.
  - Latency from a stable pin change to btn/swi change: 2 + DBNC_CYCLES cycles.
- Events are set on debounced-output transitions, detected against a registered copy of out. Event bit goes to 1 the cycle after btn/swi changes:
  - btn_prs[i]: btn[i] 0->1
  - btn_rel[i]: btn[i] 1->0
  - swi_chg[i]: any swi[i] change
  - A switch held active through reset produces swi 0->1 after debounce and sets swi_chg.
- Register map. Reads are zero-extended, and unused bits read 0.
  - addr 0, LED:
    - Read: leds.
    - Write: data_in[17:16] selects op on mask m = data_in[NUM_LED-1:0].
    - 00 load (leds <= m), 01 set (leds | m), 10 clear (leds & ~m), 11 toggle (leds ^ m).
  - addr 1, STATE (read-only, writes ignored): {16'b0, btn padded to 8 bits in [15:8], swi padded to 8 bits in [7:0]}.
  - addr 2, EVENT:
    - Read: {8'b0, swi_chg in [23:16], btn_rel in [15:8], btn_prs in [7:0]}.
    - Write: 1 clears the bit (W1C); 0 leaves it.
    - Set and W1C on the same bit in the same cycle: set wins, bit stays 1.
  - addr 3, IRQ_EN: read/write, same layout as EVENT. Bits beyond NUM_BTN/NUM_SWI are forced 0.
- Writes take effect on the clock edge where wr=1. A read in the following cycle returns the new value.
- irq <= |(EVENT & IRQ_EN), registered, so it follows a set or a clear by one cycle.
- Enabling an already-pending event raises irq on the next cycle.
- Reset asserted mid-debounce or mid-write: all state clears immediately. No event is generated on release.

Test Plan:
- DBNC_CYCLES=4: pulse btn_in[0] high for 3 cycles -> btn[0] stays 0, EVENT reads 0.
- Hold btn_in[0] high -> btn[0]=1 exactly 6 cycles after the pin edge. EVENT=0x00000001 one cycle later. Release and hold low -> EVENT=0x00000101.
- With leds=0: write 0x0000_00F0 to addr 0 (load) -> leds=0xF0. Write 0x0001_0003 (set) -> 0xF3. Write 0x0002_0030 (clear) -> 0xC3. Write 0x0003_00FF (toggle) -> 0x3C.
- IRQ_EN=0x00000001, press btn0 -> irq=1 one cycle after EVENT bit 0 sets. W1C 0x00000001 to addr 2 -> irq=0 next cycle. A W1C issued in the same cycle as a new press leaves bit 0 at 1.
- swi_in[2]=1 held through reset release -> swi=0x4 after 6 cycles, STATE=0x00000004, EVENT bit 18 set.
- Assert rst_n low mid-debounce and mid-sequence -> leds, btn, swi, EVENT, irq all 0 asynchronously, with no spurious event after release when pins are idle.

Source files
------------

// File: rtl/lsb_ev_if.sv
// Register-window bus between the CPU-side I/O bus and the LED/switch/button block.
// The master drives the write strobe, address and write data; the slave returns
// combinational read data for the selected word.
interface lsb_ev_if;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (
        output wr,
        output addr,
        output data_in,
        input  data_out
    );

    modport slave (
        input  wr,
        input  addr,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/lsb_ev.sv
// LED / switch / button I/O block.
// Buttons and switches pass through polarity correction, a 2-flop synchroniser
// and a per-input debouncer. Debounced transitions set sticky event bits that,
// when enabled, raise a registered level interrupt. LEDs accept load, set,
// clear and toggle writes so software never needs a read-modify-write.
module lsb_ev #(
    parameter int NUM_LED     = 8,
    parameter int NUM_BTN     = 4,
    parameter int NUM_SWI     = 4,
    parameter int BTN_POL     = 1,
    parameter int SWI_POL     = 1,
    parameter int DBNC_CYCLES = 20000
) (
    input  logic               clk,
    input  logic               rst_n,
    lsb_ev_if.slave            bus,
    input  logic [NUM_BTN-1:0] btn_in,
    input  logic [NUM_SWI-1:0] swi_in,
    output logic [NUM_LED-1:0] leds,
    output logic [NUM_BTN-1:0] btn,
    output logic [NUM_SWI-1:0] swi,
    output logic               irq
);

    // Buttons and switches share one synchroniser/debouncer array:
    // bits [NUM_BTN-1:0] are buttons, the upper NUM_SWI bits are switches.
    localparam int NIN = NUM_BTN + NUM_SWI;
    localparam int CW  = (DBNC_CYCLES > 1) ? $clog2(DBNC_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DBNC_CYCLES - 1);

    // Implemented bits of the EVENT / IRQ_EN layout; everything else reads 0.
    localparam logic [23:0] EVT_MASK = {8'((1 << NUM_SWI) - 1),
                                        8'((1 << NUM_BTN) - 1),
                                        8'((1 << NUM_BTN) - 1)};

    logic [NIN-1:0]     w_act;
    logic [NIN-1:0]     r_sync1;
    logic [NIN-1:0]     r_sync2;
    logic [NIN-1:0]     r_dbn;
    logic [NIN-1:0]     r_dbn_q;
    logic [CW-1:0]      r_cnt [NIN];

    logic [NUM_BTN-1:0] w_btn;
    logic [NUM_BTN-1:0] w_btn_q;
    logic [NUM_SWI-1:0] w_swi;
    logic [NUM_SWI-1:0] w_swi_q;

    logic [NUM_LED-1:0] r_leds;
    logic [NUM_LED-1:0] w_led_mask;
    logic [NUM_LED-1:0] w_led_next;
    logic [23:0]        r_evt;
    logic [23:0]        r_irq_en;
    logic [23:0]        w_evt_set;
    logic [23:0]        w_evt_clr;
    logic               r_irq;

    logic               w_wr_led;
    logic               w_wr_evt;
    logic               w_wr_en;
    logic [7:0]         w_btn8;
    logic [7:0]         w_swi8;
    logic [31:0]        w_rdata;
    logic               w_unused_bits;

    // Fold the configured active level into active-high signals.
    assign w_act[NUM_BTN-1:0]   = (BTN_POL != 0) ? btn_in : ~btn_in;
    assign w_act[NIN-1:NUM_BTN] = (SWI_POL != 0) ? swi_in : ~swi_in;

    assign w_btn   = r_dbn[NUM_BTN-1:0];
    assign w_swi   = r_dbn[NIN-1:NUM_BTN];
    assign w_btn_q = r_dbn_q[NUM_BTN-1:0];
    assign w_swi_q = r_dbn_q[NIN-1:NUM_BTN];

    assign w_wr_led = bus.wr && (bus.addr == 2'd0);
    assign w_wr_evt = bus.wr && (bus.addr == 2'd2);
    assign w_wr_en  = bus.wr && (bus.addr == 2'd3);

    assign w_unused_bits = ^bus.data_in[31:24];

    // Two-flop synchroniser for every raw pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_act;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: the output flips only after the synchronised input has differed
    // from it for DBNC_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dbn   <= '0;
            r_dbn_q <= '0;
            for (int i = 0; i < NIN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_dbn_q <= r_dbn;
            for (int i = 0; i < NIN; i++) begin
                if (r_sync2[i] == r_dbn[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_dbn[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Edge detection against the registered debounced value, plus W1C decode.
    always_comb begin
        w_evt_set                = '0;
        w_evt_set[NUM_BTN-1:0]   = w_btn & ~w_btn_q;
        w_evt_set[8 +: NUM_BTN]  = ~w_btn & w_btn_q;
        w_evt_set[16 +: NUM_SWI] = w_swi ^ w_swi_q;
        w_evt_clr                = w_wr_evt ? bus.data_in[23:0] : 24'd0;
    end

    // LED write operations selected by data_in[17:16].
    always_comb begin
        w_led_mask = bus.data_in[NUM_LED-1:0];
        w_led_next = r_leds;
        case (bus.data_in[17:16])
            2'b00:   w_led_next = w_led_mask;
            2'b01:   w_led_next = r_leds | w_led_mask;
            2'b10:   w_led_next = r_leds & ~w_led_mask;
            default: w_led_next = r_leds ^ w_led_mask;
        endcase
    end

    // Register file: LEDs, sticky events (set beats clear), enables, interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_leds   <= '0;
            r_evt    <= '0;
            r_irq_en <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_led) begin
                r_leds <= w_led_next;
            end
            if (w_wr_en) begin
                r_irq_en <= bus.data_in[23:0] & EVT_MASK;
            end
            r_evt <= ((r_evt & ~w_evt_clr) | w_evt_set) & EVT_MASK;
            r_irq <= |(r_evt & r_irq_en);
        end
    end

    // Combinational read mux, zero-extended.
    always_comb begin
        w_btn8              = '0;
        w_btn8[NUM_BTN-1:0] = w_btn;
        w_swi8              = '0;
        w_swi8[NUM_SWI-1:0] = w_swi;
        w_rdata             = '0;
        case (bus.addr)
            2'd0:    w_rdata = 32'(r_leds);
            2'd1:    w_rdata = {16'd0, w_btn8, w_swi8};
            2'd2:    w_rdata = {8'd0, r_evt};
            default: w_rdata = {8'd0, r_irq_en};
        endcase
    end

    assign bus.data_out = w_rdata;
    assign leds         = r_leds;
    assign btn          = w_btn;
    assign swi          = w_swi;
    assign irq          = r_irq;

endmodule
